uart_tx: RTL and testbench

Serial UART transmitter. It accepts one parallel byte per handshake and shifts out the frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
It runs on the same oversampled clock as the receiver, so each bit is held for `prescale` clock cycles.
It sits directly upstream of the UART receiver; TX_OUT drives the RX_IN of the receive path.

---
 rtl/uart_tx.sv | 158 +++++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s),
// each bit held for `prescale` clocks. Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      busy,
  output logic [2:0]                dbg_state
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Handshake: Data_Valid is a request sampled on a rising edge only while busy=0;
  // that edge is the acceptance, and busy stays high until the last stop cycle ends.

  state_t                    state, state_nxt;
  logic [PRESCALE_WIDTH-1:0] cnt, cnt_nxt;
  logic [PRESCALE_WIDTH-1:0] p_last, p_last_nxt;
  logic [IDX_W-1:0]          idx, idx_nxt;
  logic [DATA_WIDTH-1:0]     data_q, data_nxt;
  logic                      par_en_q, par_en_nxt;
  logic                      par_typ_q, par_typ_nxt;
  logic                      tx_nxt, busy_nxt;
  logic                      cnt_done, parity_bit;
`ifdef UART_TX_TWO_STOP_EN
  logic                      stop2_q, stop2_nxt;
`endif

  assign cnt_done   = (cnt == p_last);
  assign parity_bit = (^data_q) ^ par_typ_q;
  assign dbg_state  = state;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    p_last_nxt  = p_last;
    idx_nxt     = idx;
    data_nxt    = data_q;
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
    tx_nxt      = TX_OUT;
    busy_nxt    = busy;
`ifdef UART_TX_TWO_STOP_EN
    stop2_nxt   = stop2_q;
`endif
    if (state == IDLE) begin
      tx_nxt   = 1'b1;
      busy_nxt = 1'b0;
      if (Data_Valid) begin
        data_nxt    = P_DATA;
        par_en_nxt  = PAR_EN;
        par_typ_nxt = PAR_TYP;
        // A prescale of zero behaves as one cycle per bit.
        p_last_nxt  = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
        cnt_nxt     = '0;
        state_nxt   = START;
        tx_nxt      = 1'b0;
        busy_nxt    = 1'b1;
      end
    end else if (!cnt_done) begin
      cnt_nxt = cnt + PRESCALE_WIDTH'(1);
    end else begin
      cnt_nxt = '0;
      case (state)
        START: begin
          state_nxt = DATA;
          idx_nxt   = '0;
          tx_nxt    = data_q[0];
        end
        DATA: begin
          if (idx == IDX_W'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_nxt = PARITY;
              tx_nxt    = parity_bit;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            idx_nxt = idx + IDX_W'(1);
            tx_nxt  = data_q[idx_nxt];
          end
        end
        PARITY: begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
        STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop2_q) begin
            stop2_nxt = 1'b1;
          end else begin
            stop2_nxt = 1'b0;
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
`else
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
`endif
          tx_nxt = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      p_last    <= '0;
      idx       <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      p_last    <= p_last_nxt;
      idx       <= idx_nxt;
      data_q    <= data_nxt;
      par_en_q  <= par_en_nxt;
      par_typ_q <= par_typ_nxt;
      TX_OUT    <= tx_nxt;
      busy      <= busy_nxt;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= stop2_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames, expected frames queued by the driver and
// checked cycle by cycle by an independent line monitor.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] prescale;
  logic       TX_OUT;
  logic       busy;
  logic [2:0] dbg_state;

  int checks;
  int failures;
  int fnum;
  bit mon_active;
  // {data[31:24], P[23:16], N[15:12], frame bits[11:0] (bit 0 sent first)}
  logic [31:0] exp_q[$];

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .TX_OUT(TX_OUT), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic push_exp(input logic [7:0] data, input logic par_en, input logic exp_par,
                          input int p);
    logic [11:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = data;
    n = 9;
    if (par_en) begin
      f[9] = exp_par;
      n = 10;
    end
    n = n + NSTOP;
    exp_q.push_back({data, 8'(p), 4'(n), f});
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_active || busy) && k < budget) begin
      @(posedge CLK); #1;
      k++;
    end
    if (k >= budget) begin
      failures++;
      checks++;
      $display("FAIL wait_done_timeout: frame still pending after %0d cycles", budget);
    end
  endtask

  task automatic send(input logic [7:0] data, input logic par_en, input logic par_typ,
                      input int p, input logic exp_par);
    wait_done(2000);
    @(posedge CLK); #1;
    P_DATA = data;
    PAR_EN = par_en;
    PAR_TYP = par_typ;
    prescale = 6'(p);
    Data_Valid = 1'b1;
    push_exp(data, par_en, exp_par, p);
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
  endtask

  // monitor: checks every line cycle of a frame against the queued expectation
  task automatic mon_frame();
    logic [31:0] e;
    logic [11:0] bits;
    logic [7:0] dec;
    int n, p, bad, k;
    bit aborted;
    mon_active = 1'b1;
    aborted = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame: busy rose with no frame expected (frame %0d)", fnum);
      k = 0;
      while (busy && k < 4000) begin
        @(negedge CLK);
        k++;
      end
    end else begin
      e = exp_q.pop_front();
      bits = e[11:0];
      n = int'(e[15:12]);
      p = int'(e[23:16]);
      bad = 0;
      dec = '0;
      for (int c = 0; c < n * p; c++) begin
        if (c > 0) @(negedge CLK);
        if (!RST) begin
          aborted = 1'b1;
          break;
        end
        if (TX_OUT !== bits[c / p] || busy !== 1'b1) bad++;
        if (c % p == p / 2 && c / p >= 1 && c / p <= 8) dec[c / p - 1] = TX_OUT;
        if (c % p == p - 1) begin
          check($sformatf("f%0d_bit%0d_bad_cycles", fnum, c / p), bad, 0);
          bad = 0;
        end
      end
      if (!aborted) begin
        @(negedge CLK);
        if (RST) check($sformatf("f%0d_end_busy_tx", fnum), {busy, TX_OUT}, 2'b01);
        check($sformatf("f%0d_loopback_byte", fnum), dec, e[31:24]);
      end
    end
    fnum++;
    mon_active = 1'b0;
  endtask

  initial begin
    mon_active = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST && busy) mon_frame();
    end
  end

  // stimulus
  initial begin
    int bad, gap;
    checks = 0;
    failures = 0;
    fnum = 0;
    RST = 1'b0;
    P_DATA = '0;
    Data_Valid = 1'b0;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", {TX_OUT, busy, dbg_state}, {1'b1, 1'b0, 3'd0});
    RST = 1'b1;

    // AB, P=8, no parity
    send(8'hAB, 1'b0, 1'b0, 8, 1'b0);
    wait_done(2000);

    // reset mid-frame
    send(8'hAB, 1'b0, 1'b0, 8, 1'b0);
    repeat (19) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("async_reset_outputs", {TX_OUT, busy, dbg_state}, {1'b1, 1'b0, 3'd0});
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_after_reset_bad_cycles", bad, 0);
    check("queue_empty_after_reset", exp_q.size(), 0);

    // CD, P=16, even parity -> 1; EF, P=32, odd parity -> 0
    send(8'hCD, 1'b1, 1'b0, 16, 1'b1);
    send(8'hEF, 1'b1, 1'b1, 32, 1'b0);
    wait_done(2000);

    // request and input changes mid-frame are ignored
    send(8'hAB, 1'b0, 1'b0, 8, 1'b0);
    repeat (18) @(posedge CLK);
    #1;
    P_DATA = 8'h55;
    prescale = 6'd16;
    PAR_EN = 1'b1;
    Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    wait_done(2000);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (busy !== 1'b0) bad++;
    end
    check("no_second_frame_bad_cycles", bad, 0);

    // Data_Valid held: back-to-back frames with one idle cycle
    @(posedge CLK); #1;
    P_DATA = 8'h3C;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    prescale = 6'd8;
    Data_Valid = 1'b1;
    push_exp(8'h3C, 1'b0, 1'b0, 8);
    @(posedge CLK); #1;
    check("held_first_accept_busy", busy, 1'b1);
    P_DATA = 8'hC3;
    push_exp(8'hC3, 1'b0, 1'b0, 8);
    gap = 0;
    for (int k = 0; k < 400 && busy; k++) begin
      @(posedge CLK); #1;
    end
    for (int k = 0; k < 10 && !busy; k++) begin
      gap++;
      @(posedge CLK); #1;
    end
    Data_Valid = 1'b0;
    check("back_to_back_idle_cycles", gap, 1);
    wait_done(2000);

    repeat (5) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
